servo_pwm_bank: RTL

//  N_CH-channel servo PWM generator sharing one period counter; next generation of the single-servo driver.

---
 rtl/servo_pwm_bank.sv | 130 +++++++++++++
 1 files changed

// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM bank sharing one period counter.
// Angle settings load at period boundaries, with optional slew limiting.
module servo_pwm_bank #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int N_CH      = 4,
    parameter int ANGLE_W   = 8,
    parameter int PERIOD_US = 20000,
    parameter int MIN_US    = 1000,
    parameter int MAX_US    = 2000,
    parameter int SLEW_STEP = 0,
    localparam int CHW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [CHW-1:0]     wr_ch,
    input  logic [ANGLE_W-1:0] wr_angle,
    output logic               wr_err,
    input  logic [N_CH-1:0]    ch_en,
    output logic [N_CH-1:0]    servo_pwm,
    output logic               cycle_done
);

    localparam int CYC_US   = CLK_FREQ / 1_000_000;
    localparam int P        = PERIOD_US * CYC_US;
    localparam int MIN_CYC  = MIN_US * CYC_US;
    localparam int STEP_CYC = ((MAX_US - MIN_US) * CYC_US) / ((1 << ANGLE_W) - 1);
    localparam int CW       = $clog2(P);

    if (MAX_US >= PERIOD_US || (CLK_FREQ % 1_000_000) != 0) begin : g_cfg_check
        $error("servo_pwm_bank: invalid MAX_US/PERIOD_US/CLK_FREQ");
    end

    logic [CW-1:0]                    cnt_q, cnt_d;
    logic [N_CH-1:0][ANGLE_W-1:0]     shadow_q, shadow_d;
    logic [N_CH-1:0][ANGLE_W-1:0]     act_q, act_d;
    logic [N_CH-1:0][CW-1:0]          width_q, width_d;
    logic [N_CH-1:0]                  en_q, en_d;
    logic [N_CH-1:0]                  pwm_q, pwm_d;
    logic                             rdy_q, rdy_d;
    logic                             err_q, err_d;
    logic                             done_q, done_d;
    logic                             accept;
    logic                             boundary;

    // Moves cur toward tgt by at most SLEW_STEP, never overshooting.
    function automatic logic [ANGLE_W-1:0] slew(
        input logic [ANGLE_W-1:0] tgt,
        input logic [ANGLE_W-1:0] cur
    );
        logic [ANGLE_W-1:0] diff;
        diff = (tgt > cur) ? tgt - cur : cur - tgt;
        if (SLEW_STEP == 0 || int'(diff) <= SLEW_STEP) begin
            return tgt;
        end else if (tgt > cur) begin
            return cur + ANGLE_W'(SLEW_STEP);
        end else begin
            return cur - ANGLE_W'(SLEW_STEP);
        end
    endfunction

    always_comb begin
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        act_d    = act_q;
        width_d  = width_q;
        en_d     = en_q;
        rdy_d    = 1'b1;
        accept   = wr_valid & rdy_q;
        boundary = rdy_q && (cnt_q == CW'(P - 1));
        err_d    = accept && (int'(wr_ch) >= N_CH);

        // The first edge after reset only starts the period at cnt 0.
        if (!rdy_q || boundary) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (boundary) begin
            en_d = ch_en;
            for (int i = 0; i < N_CH; i++) begin
                act_d[i]   = slew(shadow_q[i], act_q[i]);
                width_d[i] = CW'(MIN_CYC + int'(act_d[i]) * STEP_CYC);
            end
        end

        for (int i = 0; i < N_CH; i++) begin
            if (accept && wr_ch == CHW'(i)) begin
                shadow_d[i] = wr_angle;
            end
        end

        for (int i = 0; i < N_CH; i++) begin
            pwm_d[i] = en_d[i] && (cnt_d < width_d[i]);
        end
        done_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            act_q    <= '0;
            width_q  <= {N_CH{CW'(MIN_CYC)}};
            en_q     <= '0;
            pwm_q    <= '0;
            rdy_q    <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            act_q    <= act_d;
            width_q  <= width_d;
            en_q     <= en_d;
            pwm_q    <= pwm_d;
            rdy_q    <= rdy_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign wr_ready   = rdy_q;
    assign wr_err     = err_q;
    assign servo_pwm  = pwm_q;
    assign cycle_done = done_q;

endmodule
